// File: rtl/puf_resp_pkg.sv
// Shared types and width helpers for the PUF response collector and its majority voter.
package puf_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VALID   = 2'd2
    } state_t;

    // Width of a counter that must be able to hold the value 'limit' itself.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

    function automatic bit votes_is_odd(input int votes);
        return (votes >= 1) && ((votes % 2) == 1);
    endfunction

endpackage

// File: rtl/puf_majority_voter.sv
// Counts repeated race results for one response bit and resolves it by majority.
module puf_majority_voter
    import puf_resp_pkg::*;
#(
    parameter int VOTES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic vote_en,
    input  logic winner,
    output logic bit_done,
    output logic bit_val,
    output logic unanimous
);

    localparam int VW = cnt_width(VOTES);
    localparam logic [VW-1:0] LAST = VW'(VOTES - 1);
    localparam logic [VW-1:0] HALF = VW'(VOTES / 2);
    localparam logic [VW-1:0] FULL = VW'(VOTES);

    generate
        if (!votes_is_odd(VOTES)) begin : g_bad_votes
            $error("puf_majority_voter: VOTES must be odd and >= 1");
        end
    endgenerate

    logic [VW-1:0] vote_cnt;
    logic [VW-1:0] ones_cnt;
    logic [VW-1:0] ones_final;

    // Resolution uses the count including the vote arriving this cycle, so the
    // bit is ready on the same edge that accepts the last race.
    always_comb begin
        ones_final = ones_cnt + VW'(winner);
        bit_done   = vote_en && (vote_cnt == LAST);
        bit_val    = (ones_final > HALF);
        unanimous  = (ones_final == '0) || (ones_final == FULL);
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_cnt <= '0;
            ones_cnt <= '0;
        end else if (clr) begin
            vote_cnt <= '0;
            ones_cnt <= '0;
        end else if (vote_en) begin
            if (vote_cnt == LAST) begin
                vote_cnt <= '0;
                ones_cnt <= '0;
            end else begin
                vote_cnt <= vote_cnt + VW'(1);
                ones_cnt <= ones_final;
            end
        end
    end

endmodule

// File: rtl/puf_response_collector.sv
// Collects majority-voted race-arbiter bits into a response word and hands it off via valid/ready.
module puf_response_collector
    import puf_resp_pkg::*;
#(
    parameter int RESP_WIDTH = 8,
    parameter int VOTES      = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                winner,
    input  logic                                done,
    output logic                                race_rst,
    output logic                                busy,
    output logic [RESP_WIDTH-1:0]               resp_data,
    output logic [$clog2(RESP_WIDTH+1)-1:0]     resp_unstable,
    output logic                                resp_valid,
    input  logic                                resp_ready
);

    localparam int BW = cnt_width(RESP_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(RESP_WIDTH - 1);

    state_t          state;
    state_t          state_next;
    logic            race_hold;
    logic [BW-1:0]   bit_cnt;
    logic            accept;
    logic            new_word;
    logic            bit_done;
    logic            bit_val;
    logic            unanimous;
    logic [RESP_WIDTH-1:0] shifted;

    assign accept   = (state == COLLECT) && done && !race_hold;
    assign new_word = start && ((state == IDLE) || ((state == VALID) && resp_ready));

    puf_majority_voter #(
        .VOTES (VOTES)
    ) u_voter (
        .clk       (clk),
        .rst       (rst),
        .clr       (new_word),
        .vote_en   (accept),
        .winner    (winner),
        .bit_done  (bit_done),
        .bit_val   (bit_val),
        .unanimous (unanimous)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: if (bit_done && (bit_cnt == LAST_BIT)) state_next = VALID;
            VALID:   if (resp_ready) state_next = start ? COLLECT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == COLLECT);
        resp_valid = (state == VALID);
        race_rst   = (state != COLLECT) || race_hold;
    end

    always_comb begin
        if (MSB_FIRST) shifted = (resp_data << 1) | RESP_WIDTH'(bit_val);
        else           shifted = (resp_data >> 1) | (RESP_WIDTH'(bit_val) << (RESP_WIDTH - 1));
    end

    // race_hold keeps the arbiter in reset for the single cycle after each accepted race.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            race_hold     <= 1'b0;
            bit_cnt       <= '0;
            resp_data     <= '0;
            resp_unstable <= '0;
        end else if (new_word) begin
            race_hold     <= 1'b0;
            bit_cnt       <= '0;
            resp_data     <= '0;
            resp_unstable <= '0;
        end else begin
            race_hold <= accept;
            if (accept && bit_done) begin
                resp_data     <= shifted;
                resp_unstable <= resp_unstable + BW'(!unanimous);
                bit_cnt       <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_puf_response_collector.sv
// Directed bench with a scoreboard for three collector configurations sharing clk/rst.
module tb_puf_response_collector;

    typedef struct {
        logic [7:0] data;
        logic [3:0] unst;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instances a (MSB first) and l (LSB first) share stimulus; v is W=4, V=3.
    logic start_a = 0, winner_a = 0, done_a = 0, ready_a = 0;
    logic start_v = 0, winner_v = 0, done_v = 0, ready_v = 0;

    logic       race_rst_a, busy_a, valid_a;
    logic [7:0] data_a;
    logic [3:0] unst_a;
    logic       race_rst_l, busy_l, valid_l;
    logic [7:0] data_l;
    logic [3:0] unst_l;
    logic       race_rst_v, busy_v, valid_v;
    logic [3:0] data_v;
    logic [2:0] unst_v;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_l[$];
    exp_t q_v[$];

    puf_response_collector #(.RESP_WIDTH(8), .VOTES(1), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .winner(winner_a), .done(done_a),
        .race_rst(race_rst_a), .busy(busy_a), .resp_data(data_a),
        .resp_unstable(unst_a), .resp_valid(valid_a), .resp_ready(ready_a)
    );

    puf_response_collector #(.RESP_WIDTH(8), .VOTES(1), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .start(start_a), .winner(winner_a), .done(done_a),
        .race_rst(race_rst_l), .busy(busy_l), .resp_data(data_l),
        .resp_unstable(unst_l), .resp_valid(valid_l), .resp_ready(ready_a)
    );

    puf_response_collector #(.RESP_WIDTH(4), .VOTES(3), .MSB_FIRST(1'b1)) dut_v (
        .clk(clk), .rst(rst), .start(start_v), .winner(winner_v), .done(done_v),
        .race_rst(race_rst_v), .busy(busy_v), .resp_data(data_v),
        .resp_unstable(unst_v), .resp_valid(valid_v), .resp_ready(ready_v)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic race_a(input logic b);
        winner_a = b;
        done_a   = 1'b1;
        tick();
        done_a   = 1'b0;
        check("race_rst_after_done", race_rst_a, 1);
        tick();
    endtask

    task automatic race_v(input logic b);
        winner_v = b;
        done_v   = 1'b1;
        tick();
        done_v   = 1'b0;
        tick();
    endtask

    // Waits (bounded) for the word on instances a and l, then compares against the scoreboard.
    task automatic check_word_a(output exp_t held);
        exp_t ea;
        exp_t el;
        for (int i = 0; i < 8 && valid_a !== 1'b1; i++) tick();
        check("valid_a_timeout", valid_a, 1);
        check("valid_l_timeout", valid_l, 1);
        if (q_a.size() == 0 || q_l.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            held = '{8'h00, 4'h0};
        end else begin
            ea = q_a.pop_front();
            el = q_l.pop_front();
            check("data_msb", data_a, ea.data);
            check("unstable_msb", unst_a, ea.unst);
            check("data_lsb", data_l, el.data);
            check("unstable_lsb", unst_l, el.unst);
            held = ea;
        end
    endtask

    task automatic start_word_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        exp_t held;
        logic [7:0] pat;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
        logic [2:0] votes_tbl [12];

        // Reset state.
        tick();
        tick();
        check("rst_race_rst", race_rst_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_data", data_a, 0);
        check("rst_unstable", unst_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_valid_v", valid_v, 0);
        rst = 1'b0;
        tick();

        // Word 1: bits 1,0,1,1,0,0,1,0; first bit offered on two consecutive cycles.
        q_a.push_back('{8'hB2, 4'd0});
        q_l.push_back('{8'h4D, 4'd0});
        start_word_a();
        check("collect_busy", busy_a, 1);
        check("collect_race_rst_low", race_rst_a, 0);
        winner_a = 1'b1;
        done_a   = 1'b1;
        tick();
        winner_a = 1'b0;
        tick();
        done_a   = 1'b0;
        check("dropped_done_race_rst_low", race_rst_a, 0);
        race_a(0); race_a(1); race_a(1); race_a(0); race_a(0); race_a(1);
        check("no_valid_before_last", valid_a, 0);
        winner_a = 1'b0;
        done_a   = 1'b1;
        tick();
        done_a   = 1'b0;
        check("valid_cycle_after_last_done", valid_a, 1);
        check_word_a(held);

        // Back-pressure with stray dones in VALID.
        for (int i = 0; i < 10; i++) begin
            done_a   = i[0];
            winner_a = 1'b1;
            tick();
            check("bp_valid", valid_a, 1);
            check("bp_data", data_a, held.data);
            check("bp_race_rst", race_rst_a, 1);
        end
        done_a = 1'b0;

        // Back-to-back: ready and start on the same edge.
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        ready_a = 1'b0;
        start_a = 1'b0;
        check("b2b_valid_low", valid_a, 0);
        check("b2b_busy", busy_a, 1);
        check("b2b_data_clr", data_a, 0);
        check("b2b_unstable_clr", unst_a, 0);
        check("b2b_race_rst_low", race_rst_a, 0);

        // Word 2: random pattern, expected values from a bit-order model.
        pat = 8'($urandom);
        exp_msb = '0;
        exp_lsb = '0;
        for (int k = 0; k < 8; k++) begin
            exp_msb = {exp_msb[6:0], pat[7-k]};
            exp_lsb = {pat[7-k], exp_lsb[7:1]};
        end
        q_a.push_back('{exp_msb, 4'd0});
        q_l.push_back('{exp_lsb, 4'd0});
        for (int k = 0; k < 8; k++) race_a(pat[7-k]);
        check_word_a(held);

        // Handshake without start: IDLE, data retained, dones ignored.
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check("idle_valid_low", valid_a, 0);
        check("idle_busy_low", busy_a, 0);
        check("idle_data_kept", data_a, held.data);
        done_a   = 1'b1;
        winner_a = 1'b1;
        tick();
        tick();
        done_a   = 1'b0;
        check("idle_done_ignored", data_a, held.data);

        // Asynchronous reset after 5 of 8 bits.
        start_word_a();
        for (int k = 0; k < 5; k++) race_a(1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_race_rst", race_rst_a, 1);
        check("arst_data", data_a, 0);
        check("arst_valid", valid_a, 0);
        tick();
        rst = 1'b0;
        tick();

        // Word 3 after reset: no leftover bits from the partial word.
        pat = 8'h5A;
        q_a.push_back('{8'h5A, 4'd0});
        q_l.push_back('{8'h5A, 4'd0});
        start_word_a();
        for (int k = 0; k < 8; k++) race_a(pat[7-k]);
        check_word_a(held);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;

        // W=4, V=3: votes {1,1,1},{1,0,1},{0,0,1},{0,0,0}.
        votes_tbl = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
        q_v.push_back('{8'h0C, 4'd2});
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        check("vote_busy", busy_v, 1);
        for (int k = 0; k < 12; k++) race_v(votes_tbl[k][0]);
        for (int i = 0; i < 8 && valid_v !== 1'b1; i++) tick();
        check("vote_valid_timeout", valid_v, 1);
        if (q_v.size() == 0) begin
            check("scoreboard_empty_v", 0, 1);
        end else begin
            held = q_v.pop_front();
            check("vote_data", data_v, held.data);
            check("vote_unstable", unst_v, held.unst);
        end
        ready_v = 1'b1;
        tick();
        ready_v = 1'b0;
        check("vote_idle", valid_v, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_response_collector.md
Name: puf_response_collector

Overview:
Parametrised successor to the race-response buffer. Collects RESP_WIDTH response bits from the race arbiter. Each bit is resolved by majority vote over VOTES repeated races. The block sequences the arbiter reset between races, reports how many bits had non-unanimous votes, and hands the finished word downstream over a valid/ready handshake. It sits between the race arbiter and the response readout/UART path.

Parameters:
RESP_WIDTH, 8, number of response bits per challenge (>=1)
VOTES, 1, races per response bit; must be odd (>=1); 1 = no voting
MSB_FIRST, 1, 1: first resolved bit ends at resp_data[RESP_WIDTH-1]; 0: first bit ends at resp_data[0]

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to begin a new response
winner  input  1  race result from arbiter, qualified by done
done  input  1  arbiter race-complete strobe
race_rst  output  1  arbiter/counter reset request between races
busy  output  1  high while in COLLECT
resp_data  output  RESP_WIDTH  assembled response word
resp_unstable  output  $clog2(RESP_WIDTH+1)  count of bits whose votes were not unanimous
resp_valid  output  1  resp_data/resp_unstable valid
resp_ready  input  1  downstream accepts the word

Behaviour:
- Single clock, clk. rst is asynchronous and active-high. Reset values: state=IDLE, race_rst=1, busy=0, resp_data=0, resp_unstable=0, resp_valid=0, and all internal counters 0.
- FSM has three states: IDLE, COLLECT, VALID.
- IDLE:
  - race_rst=1. done is ignored.
  - When start=1: clear resp_data, resp_unstable, bit counter and vote counters, then go to COLLECT next cycle.
- COLLECT:
  - busy=1. race_rst=1 for exactly the one cycle after each accepted done, otherwise 0.
  - done is accepted only when race_rst=0. done while race_rst=1 is dropped.
  - On an accepted done: vote_cnt+1, and ones_cnt+winner.
  - When vote_cnt reaches VOTES, resolve the bit:
    - bit = (ones_cnt_final > VOTES/2).
    - If ones_cnt_final is neither 0 nor VOTES, resp_unstable+1.
    - Shift the bit in. MSB_FIRST=1: resp_data <= {resp_data[W-2:0], bit}. MSB_FIRST=0: resp_data <= {bit, resp_data[W-1:1]}.
    - Clear vote_cnt and ones_cnt, and increment bit_cnt.
  - Resolving the RESP_WIDTH-th bit goes to VALID on the same edge. resp_valid is high in the cycle after the final done, and the final bit is already present in resp_data.
  - start in COLLECT is ignored (no restart).
- VALID:
  - resp_valid=1, race_rst=1. resp_data and resp_unstable are held stable. done is ignored.
  - Handshake completes on a clk edge with resp_valid & resp_ready.
  - resp_ready & start on the same edge: back-to-back. Clear accumulators and go straight to COLLECT. resp_valid drops next cycle.
  - resp_ready without start: go to IDLE. resp_data and resp_unstable retain their values until the next start.
- resp_valid must never fall without a handshake, except on rst.
- Width rules:
  - bit_cnt is $clog2(RESP_WIDTH+1) bits.
  - vote_cnt and ones_cnt are $clog2(VOTES+1) bits.
  - No counter wraps: each is cleared on reaching its limit.
- Reset mid-operation: asserting rst in any state forces the reset values immediately. A partial word is discarded, and no resp_valid is produced for it.
- VOTES=1: every bit is unanimous, so resp_unstable stays 0 and behaviour reduces to a plain shift collector.

Decomposition:
- Package puf_resp_pkg holds:
  - the state typedef (IDLE, COLLECT, VALID);
  - width helper functions (counter widths from RESP_WIDTH/VOTES);
  - the elaboration check that VOTES is odd.
- One sub-module, puf_majority_voter (parameter VOTES). Inputs: clk, rst, clr, vote_en, winner. Outputs: bit_done, bit_val, unanimous.
- The top level holds the FSM, shift register, bit counter and handshake.

Test Plan:
- Defaults (W=8, V=1, MSB_FIRST=1): start, then 8 accepted dones with winner=1,0,1,1,0,0,1,0 -> resp_data=8'hB2, resp_unstable=0. resp_valid rises the cycle after the 8th done and holds until resp_ready.
- MSB_FIRST=0, same stimulus -> resp_data=8'h4D.
- V=3, W=4: votes per bit {1,1,1},{1,0,1},{0,0,1},{0,0,0} -> resp_data=4'b1100, resp_unstable=2.
- race_rst and drop behaviour:
  - done asserted on two consecutive cycles in COLLECT: only the first is counted, because race_rst=1 in the second cycle.
  - done in IDLE or VALID is ignored, and bit_cnt is unchanged.
- Back-pressure and back-to-back:
  - Hold resp_ready=0 for 10 cycles: resp_data and resp_valid stay stable.
  - Then resp_ready=1 together with start=1: the next cycle is COLLECT with resp_valid=0 and the accumulators cleared.
  - A second word then completes correctly.
- Asynchronous reset mid-word: rst after 5 of 8 bits -> outputs return to reset values immediately.
  - A subsequent start plus 8 dones gives a correct word with no leftover bits.
